// File: rtl/pipe_register.sv
// pipe_register: multi-stage valid/ready pipeline register with bubble collapse and synchronous flush
module pipe_register #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_register: DEPTH must be >= 1");
  end
  logic [DEPTH-1:0] v, rdy;
  logic [DEPTH:0] vin;
  logic [WIDTH-1:0] data [DEPTH];
  logic [WIDTH-1:0] din [DEPTH+1];
  logic r;
  // a stage can load if it is empty or everything ahead of it can move
  always_comb begin
    r = out_ready;
    rdy = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      r = !v[i] | r;
      rdy[i] = r;
    end
  end
  assign in_ready = rdy[0] & !flush;
  assign vin = {v, in_valid & in_ready};
  always_comb begin
    din[0] = in_data;
    for (int i = 0; i < DEPTH; i++) din[i+1] = data[i];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) data[i] <= RESET_VALUE;
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (rdy[i]) begin
          v[i] <= vin[i];
          if (vin[i]) data[i] <= din[i];
        end
    end
  assign out_valid = v[DEPTH-1];
  assign out_data = data[DEPTH-1];
  assign count = $bits(count)'($countones(v));
endmodule

// File: tb/tb_pipe_register.sv
// tb_pipe_register: directed and random checks of pipe_register against a position-queue model
module tb_pipe_register;
  typedef struct {
    int         pos;
    logic [7:0] data;
  } item_t;

  logic clk = 1'b0;
  logic reset_n, flush, in_valid, out_ready;
  logic [7:0] in_data;
  logic ir[3], ov[3];
  logic [7:0] od[3];
  logic [1:0] c3;
  logic c1;
  logic [2:0] c4;
  logic [31:0] cnt[3];
  int act;
  int deps[3] = '{3, 1, 4};
  int checks = 0, errors = 0;
  item_t mq[$], nq[$];
  int lim;
  bit acc;

  initial forever #5 clk = ~clk;

  pipe_register #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'hA5)) u_d3 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .count(c3));
  pipe_register #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(8'hA5)) u_d1 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .count(c1));
  pipe_register #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'hA5)) u_d4 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .count(c4));

  assign cnt[0] = 32'(c3);
  assign cnt[1] = 32'(c1);
  assign cnt[2] = 32'(c4);

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  // items packed toward the output; each advances one stage unless blocked by the item ahead
  always @(posedge clk or negedge reset_n)
    if (!reset_n || flush) mq.delete();
    else begin
      nq.delete();
      lim = deps[act];
      acc = in_valid && (mq.size() < deps[act] || out_ready);
      foreach (mq[k]) begin
        if (k == 0 && mq[0].pos == deps[act]-1 && out_ready) continue;
        nq.push_back('{pos: (mq[k].pos + 1 < lim) ? mq[k].pos + 1 : mq[k].pos, data: mq[k].data});
        lim = nq[$].pos;
      end
      if (acc) nq.push_back('{pos: 0, data: in_data});
      mq = nq;
    end

  always @(negedge clk)
    if (reset_n) begin
      chk("m_in_ready", 32'(ir[act]), 32'(!flush && (mq.size() < deps[act] || out_ready)));
      chk("m_out_valid", 32'(ov[act]), 32'(mq.size() > 0 && mq[0].pos == deps[act]-1));
      chk("m_count", cnt[act], 32'(mq.size()));
      if (mq.size() > 0 && mq[0].pos == deps[act]-1)
        chk("m_out_data", 32'(od[act]), 32'(mq[0].data));
    end

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; act = 0;
    #12 reset_n = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 8'h0A; tick();
    in_data = 8'h0B; tick();
    chk("pre_rst_count", cnt[0], 2);
    #2 reset_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 32'(ov[0]), 0);
    chk("rst_count", cnt[0], 0);
    chk("rst_out_data", 32'(od[0]), 32'h A5);
    #3 reset_n = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int c = 0; c < 19; c++) begin
      in_valid = (c < 16);
      in_data = 8'(c + 1);
      nedge();
      if (c == 2) chk("stream_latency", 32'(ov[0]), 0);
      if (c >= 3) begin
        chk("stream_valid", 32'(ov[0]), 1);
        chk("stream_data", 32'(od[0]), 32'(c - 2));
      end
      tick();
    end
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_data = 8'h33; tick();
    in_data = 8'h44;
    nedge();
    chk("full_in_ready", 32'(ir[0]), 0);
    chk("full_count", cnt[0], 3);
    tick();
    out_ready = 1'b1;
    nedge();
    chk("drain_d0", 32'(od[0]), 32'h11);
    chk("drain_in_ready", 32'(ir[0]), 1);
    tick();
    in_valid = 1'b0;
    nedge(); chk("drain_d1", 32'(od[0]), 32'h22); tick();
    nedge(); chk("drain_d2", 32'(od[0]), 32'h33); tick();
    nedge(); chk("drain_d3", 32'(od[0]), 32'h44); tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h55; tick();
    in_valid = 1'b0; tick(); tick();
    in_valid = 1'b1; in_data = 8'h66;
    nedge();
    chk("bubble_one", cnt[0], 1);
    chk("bubble_in_ready", 32'(ir[0]), 1);
    tick();
    in_data = 8'h77;
    nedge();
    chk("bubble_count2", cnt[0], 2);
    chk("bubble_in_ready2", 32'(ir[0]), 1);
    tick();
    in_valid = 1'b0;
    nedge();
    chk("bubble_count3", cnt[0], 3);
    tick();
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    nedge();
    chk("flush_in_ready", 32'(ir[0]), 0);
    chk("flush_out_valid", 32'(ov[0]), 1);
    chk("flush_out_data", 32'(od[0]), 32'h55);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    nedge();
    chk("post_flush_count", cnt[0], 0);
    chk("post_flush_valid", 32'(ov[0]), 0);
    tick();
    for (int d = 1; d <= 2; d++) begin
      act = d;
      reset_n = 1'b0; tick();
      reset_n = 1'b1; tick();
      for (int c = 0; c < 10000; c++) begin
        in_valid = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        in_data = 8'($urandom);
        flush = ($urandom_range(0, 63) == 0);
        if (d == 1) begin
          nedge();
          chk("d1_count_max", 32'(cnt[1] <= 1), 1);
        end
        tick();
      end
      in_valid = 1'b0; flush = 1'b0;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
